// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch serial reporting path.
// Holds the transmit FSM state encoding and the ASCII framing bytes.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } txstate_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Byte at position idx of a frame: tens digit, ones digit, CR, LF.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [1:0] tens,
                                            input logic [3:0] ones);
    case (idx)
      2'd0:    return ASCII_ZERO + {6'd0, tens};
      2'd1:    return ASCII_ZERO + {4'd0, ones};
      2'd2:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/bin2dec.sv
// Combinational split of a 0..31 count into decimal tens (0..3) and ones (0..9).
module bin2dec (
  input  logic [4:0] bin,
  output logic [1:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 2'd0;
    ones = bin[3:0];
    if (bin >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(bin - 5'd30);
    end else if (bin >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(bin - 5'd20);
    end else if (bin >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(bin - 5'd10);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Sends a 0..31 count to a byte-wide UART as two ASCII digits plus CR[/LF].
// Every output is a register loaded from the next-state values.
module count_uart_tx
  import stopwatch_pkg::*;
#(
  parameter int TERM_LF = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       send,
  input  logic [4:0] value,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       done,
  output txstate_t   state
);

  localparam logic [1:0] LAST_IDX = (TERM_LF != 0) ? 2'd3 : 2'd2;

  txstate_t   state_d;
  logic [1:0] idx, idx_d;
  logic [4:0] value_q, value_d;
  logic [1:0] tens;
  logic [3:0] ones;

  // Decode the latch's D side so the first byte is ready in the first WAIT cycle.
  bin2dec u_bin2dec (
    .bin  (value_d),
    .tens (tens),
    .ones (ones)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    value_d = value_q;
    case (state)
      IDLE: begin
        if (send) begin
          state_d = WAIT;
          idx_d   = 2'd0;
          value_d = value;
        end
      end
      WAIT:    if (txready) state_d = PULSE;
      PULSE:   state_d = (idx == LAST_IDX) ? FIN : GAP;
      GAP: begin
        state_d = WAIT;
        idx_d   = idx + 2'd1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      value_q <= 5'd0;
      txdata  <= 8'h00;
      txclk   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      value_q <= value_d;
      txdata  <= (state_d == IDLE) ? 8'h00 : frame_byte(idx_d, tens, ones);
      txclk   <= (state_d == PULSE);
      busy    <= (state_d != IDLE);
      done    <= (state_d == FIN);
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: CR+LF instance plus a CR-only instance.
// Frame bytes go through an expected queue and are matched against captured strobes.
module tb_count_uart_tx;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       nrst, send, send3, txready;
  logic [4:0] value;
  logic [7:0] txdata, txdata3;
  logic       txclk, busy, done, txclk3, busy3, done3;
  txstate_t   state, state3;

  logic [7:0] exp_q[$], rx_q[$], exp3_q[$], rx3_q[$];
  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  count_uart_tx #(.TERM_LF(1)) dut (
    .clk(clk), .nrst(nrst), .send(send), .value(value), .txready(txready),
    .txdata(txdata), .txclk(txclk), .busy(busy), .done(done), .state(state)
  );

  count_uart_tx #(.TERM_LF(0)) dut3 (
    .clk(clk), .nrst(nrst), .send(send3), .value(value), .txready(txready),
    .txdata(txdata3), .txclk(txclk3), .busy(busy3), .done(done3), .state(state3)
  );

  // Capture every byte strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (txclk === 1'b1) rx_q.push_back(txdata);
    if (txclk3 === 1'b1) rx3_q.push_back(txdata3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int v, input bit lf, input bit to3);
    logic [7:0] b[4];
    b[0] = 8'h30 + 8'(v / 10);
    b[1] = 8'h30 + 8'(v % 10);
    b[2] = 8'h0D;
    b[3] = 8'h0A;
    for (int i = 0; i < (lf ? 4 : 3); i++) begin
      if (to3) exp3_q.push_back(b[i]);
      else exp_q.push_back(b[i]);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; send = 1'b0; send3 = 1'b0; txready = 1'b1; value = 5'd0;
    tick(); tick();
    tests_run++;
    if ({txdata, txclk, busy, done} !== 11'd0 || state !== IDLE) begin
      fails++;
      $display("FAIL reset_outputs: got txdata=%h txclk=%b busy=%b done=%b state=%0d, required all 0 / IDLE",
               txdata, txclk, busy, done, state);
    end
    tests_run++;
    if ({txdata3, txclk3, busy3, done3} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs_cr: got txdata=%h txclk=%b busy=%b done=%b, required 0",
               txdata3, txclk3, busy3, done3);
    end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic_timing();
    logic [7:0] e, g;
    value = 5'd27; send = 1'b1;
    push_frame(27, 1'b1, 1'b0);
    tick();
    send = 1'b0;
    value = 5'd3;
    for (int c = 1; c <= 13; c++) begin
      tests_run++;
      if (txclk !== (c == 2 || c == 5 || c == 8 || c == 11)) begin
        fails++;
        $display("FAIL basic_txclk cycle %0d: got %b", c, txclk);
      end
      tests_run++;
      if (done !== (c == 12)) begin
        fails++;
        $display("FAIL basic_done cycle %0d: got %b", c, done);
      end
      tests_run++;
      if (busy !== (c <= 12)) begin
        fails++;
        $display("FAIL basic_busy cycle %0d: got %b required %b", c, busy, c <= 12);
      end
      tick();
    end
    tests_run++;
    if (txdata !== 8'h00) begin
      fails++;
      $display("FAIL idle_txdata: got %h required 00", txdata);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests_run++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL basic_byte: got none required %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin fails++; $display("FAIL basic_byte: got %h required %h", g, e); end end
    end
    tests_run++;
    if (rx_q.size() != 0) begin fails++; $display("FAIL basic_extra: got %0d extra bytes required 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    bit ok;
    int vals[2] = '{0, 31};
    for (int f = 0; f < 2; f++) begin
      value = 5'(vals[f]); send = 1'b1;
      push_frame(vals[f], 1'b1, 1'b0);
      tick();
      send = 1'b0;
      wait_done(40, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL b2b_done frame %0d: got no done required done", f); end
      // send during FIN must not start another frame
      send = 1'b1;
      tick();
      send = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || state !== IDLE) begin
        fails++;
        $display("FAIL fin_send_ignored: got busy=%b state=%0d required 0/IDLE", busy, state);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin fails++; $display("FAIL fin_send_busy: got %b required 0", busy); end
      tests_run++;
      if (rx_q.size() != 4) begin fails++; $display("FAIL b2b_pulses frame %0d: got %0d required 4", f, rx_q.size()); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); tests_run++;
        if (rx_q.size() == 0) begin fails++; $display("FAIL b2b_byte: got none required %h", e); end
        else begin g = rx_q.pop_front(); if (g !== e) begin fails++; $display("FAIL b2b_byte: got %h required %h", g, e); end end
      end
      rx_q.delete();
    end
  endtask

  task automatic test_stall();
    logic [7:0] e, g;
    bit ok;
    txready = 1'b0; value = 5'd9; send = 1'b1;
    push_frame(9, 1'b1, 1'b0);
    tick();
    send = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tests_run++;
      if (state !== WAIT || txdata !== 8'h30 || txclk !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall cycle %0d: got state=%0d txdata=%h txclk=%b busy=%b required WAIT/30/0/1",
                 c, state, txdata, txclk, busy);
      end
      tick();
    end
    txready = 1'b1;
    tick();
    tests_run++;
    if (txclk !== 1'b1 || txdata !== 8'h30) begin
      fails++;
      $display("FAIL stall_release: got txclk=%b txdata=%h required 1/30", txclk, txdata);
    end
    wait_done(40, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL stall_done: got no done required done"); end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests_run++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL stall_byte: got none required %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin fails++; $display("FAIL stall_byte: got %h required %h", g, e); end end
    end
    tests_run++;
    if (rx_q.size() != 0) begin fails++; $display("FAIL stall_extra: got %0d extra bytes required 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_ignore_send();
    logic [7:0] e, g;
    bit ok;
    bit saw_busy = 1'b0;
    value = 5'd12; send = 1'b1;
    push_frame(12, 1'b1, 1'b0);
    tick();
    send = 1'b0;
    tick();
    value = 5'd5; send = 1'b1;
    tick();
    send = 1'b0;
    tick(); tick();
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_done(40, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL ignore_done: got no done required done"); end
    tick();
    for (int c = 0; c < 15; c++) begin
      if (busy !== 1'b0) saw_busy = 1'b1;
      tick();
    end
    tests_run++;
    if (saw_busy) begin fails++; $display("FAIL ignore_second_frame: got busy after frame required idle"); end
    tests_run++;
    if (rx_q.size() != 4) begin fails++; $display("FAIL ignore_pulses: got %0d required 4", rx_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests_run++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL ignore_byte: got none required %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin fails++; $display("FAIL ignore_byte: got %h required %h", g, e); end end
    end
    rx_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e, g;
    bit ok;
    int stray = 0;
    value = 5'd12; send = 1'b1;
    exp_q.push_back(8'h31);
    tick();
    send = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (state !== WAIT || txdata !== 8'h32) begin
      fails++;
      $display("FAIL mid_second_wait: got state=%0d txdata=%h required WAIT/32", state, txdata);
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tests_run++;
    if ({txdata, txclk, busy, done} !== 11'd0 || state !== IDLE) begin
      fails++;
      $display("FAIL mid_reset_outputs: got txdata=%h txclk=%b busy=%b done=%b state=%0d required 0/IDLE",
               txdata, txclk, busy, done, state);
    end
    for (int c = 0; c < 15; c++) begin
      if (txclk !== 1'b0 || done !== 1'b0) stray++;
      tick();
    end
    tests_run++;
    if (stray != 0) begin fails++; $display("FAIL mid_reset_quiet: got %0d strobe cycles required 0", stray); end
    value = 5'd5; send = 1'b1;
    push_frame(5, 1'b1, 1'b0);
    tick();
    send = 1'b0;
    wait_done(40, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL mid_new_done: got no done required done"); end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests_run++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL mid_byte: got none required %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin fails++; $display("FAIL mid_byte: got %h required %h", g, e); end end
    end
    tests_run++;
    if (rx_q.size() != 0) begin fails++; $display("FAIL mid_extra: got %0d extra bytes required 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_term_cr();
    logic [7:0] e, g;
    value = 5'd14; send3 = 1'b1;
    push_frame(14, 1'b0, 1'b1);
    tick();
    send3 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tests_run++;
      if (txclk3 !== (c == 2 || c == 5 || c == 8)) begin
        fails++;
        $display("FAIL cr_txclk cycle %0d: got %b", c, txclk3);
      end
      tests_run++;
      if (done3 !== (c == 9)) begin
        fails++;
        $display("FAIL cr_done cycle %0d: got %b", c, done3);
      end
      tick();
    end
    while (exp3_q.size() > 0) begin
      e = exp3_q.pop_front(); tests_run++;
      if (rx3_q.size() == 0) begin fails++; $display("FAIL cr_byte: got none required %h", e); end
      else begin g = rx3_q.pop_front(); if (g !== e) begin fails++; $display("FAIL cr_byte: got %h required %h", g, e); end end
    end
    tests_run++;
    if (rx3_q.size() != 0) begin fails++; $display("FAIL cr_extra: got %0d extra bytes required 0", rx3_q.size()); rx3_q.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_timing();
    test_back_to_back();
    test_stall();
    test_ignore_send();
    test_reset_mid_frame();
    test_term_cr();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
